seven_seg_scan_driver: RTL and testbench
========================================

// Module: seven_seg_scan_driver
// PURPOSE
//  Time-multiplexed N-digit seven-segment display driver. It latches a packed hex word, then scans digits one at a time.
//  For each digit it drives a shared active-low segment bus plus an active-low one-hot digit enable.
//  Sits between datapath result registers and board display pins; replaces one combinational decoder per digit.
//  Adds double-buffered loads (no frame tearing), leading-zero suppression, global blank and per-digit DP.
// PARAMETERS
//  NUM_DIGITS   4      digits scanned (>=2); digit 0 = least significant, rightmost
//  REFRESH_DIV  50000  clock cycles each digit stays enabled (>=2)
//  CNT_W        16     prescaler width; must hold REFRESH_DIV-1
// PORTS
//  Clk         in   1              system clock, all logic on rising edge
//  Rst         in   1              synchronous, active-low reset
//  LoadEn      in   1              1-cycle strobe: capture DataIn/DpIn into pending buffer
//  DataIn      in   4*NUM_DIGITS   packed nibbles, DataIn[4k+3:4k] = digit k
//  DpIn        in   NUM_DIGITS     decimal point request per digit, 1 = lit
//  LzSuppress  in   1              1 = blank leading zero digits
//  BlankEn     in   1              1 = all segments and DP off (scan keeps running)
//  SegOut      out  7              {g,f,e,d,c,b,a}, active-low
//  DpOut       out  1              decimal point, active-low
//  DigitSel    out  NUM_DIGITS     digit enable, active-low one-hot
//  FrameStart  out  1              1-cycle pulse when digit 0 becomes active
// BEHAVIOUR
//  Reset (Rst=0 at edge):
//   - prescaler=0, digit index=0, pending and display buffers=0, pend_valid=0.
//   - SegOut=7'h7F, DpOut=1, DigitSel=all 1s, FrameStart=0.
//  Prescaler:
//   - counts 0..REFRESH_DIV-1 and wraps; tick = (count==REFRESH_DIV-1).
//   - On tick, index <= (index==NUM_DIGITS-1) ? 0 : index+1.
//   - frame boundary = tick while index==NUM_DIGITS-1.
//  Load:
//   - LoadEn=1: pending <= {DataIn,DpIn}; pend_valid <= 1.
//   - At frame boundary with pend_valid=1: display <= pending; pend_valid <= 0.
//   - LoadEn at the frame boundary cycle: incoming data goes straight to display; pend_valid stays 0.
//   - Back-to-back loads inside one frame: last one wins.
//  Outputs: registered, 1-cycle latency from index/display/control to pins.
//   - DigitSel[index]=0, all other bits 1; exactly one digit low at all times after the first post-reset cycle.
//   - FrameStart=1 exactly in the first cycle DigitSel[0] goes low after a wrap; also 1 in the first cycle after reset release.
//  Decode of nibble (SegOut hex):
//   - 0:40  1:79  2:24  3:30  4:19  5:12  6:02  7:78
//   - 8:00  9:18  A:08  b:03  C:46  d:21  E:06  F:0E
//  Leading-zero suppression, when LzSuppress=1:
//   - Digit k is blank (SegOut=7F) iff all display nibbles k..NUM_DIGITS-1 are 0 and k!=0.
//   - Digit 0 is never suppressed; DP of a suppressed digit still follows DpIn.
//  BlankEn=1: SegOut=7F and DpOut=1 for every digit. BlankEn, LzSuppress take effect next cycle, not frame-aligned.
//  Reset mid-frame: pending load is discarded and the scan restarts at digit 0.
// TESTING (NUM_DIGITS=4, REFRESH_DIV=4)
//  1 Reset:
//    - Rst=0 3 cycles -> SegOut=7F, DpOut=1, DigitSel=4'hF.
//    - Release -> DigitSel=4'hE, SegOut=40 each 4-cycle slot, order E,D,B,7, FrameStart every 16 cycles.
//  2 Load mid-frame:
//    - LoadEn with DataIn=16'h12AF during digit 1 -> old value shown until frame boundary.
//    - Next frame: digit0..3 SegOut = 0E, 08, 24, 79.
//  3 Load coincident with frame boundary:
//    - LoadEn, DataIn=16'h0009 on tick with index=3 -> following frame shows 18 on digit 0 immediately.
//    - Back-to-back loads 16'h1111 then 16'h2222 in one frame -> only 2222 displayed.
//  4 Leading-zero suppression:
//    - DataIn=16'h0050, LzSuppress=1 -> digit3=7F, digit2=7F, digit1=12, digit0=40.
//    - DataIn=16'h0000 -> only digit 0 lit (40).
//    - DpIn=4'b1000 -> digit3 DpOut=0 while its SegOut=7F.
//  5 BlankEn:
//    - BlankEn=1 mid-digit -> next cycle SegOut=7F, DpOut=1; DigitSel keeps scanning.
//    - Deassert -> segments resume next cycle.
//  6 Reset mid-operation:
//    - LoadEn 16'hBEEF, then Rst=0 before frame boundary -> after release display=0000 (digit0=40) and pending value never appears.

Source files
------------

// File: rtl/seven_seg_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : seven_seg_scan_driver
// Brief    : Time-multiplexed N-digit seven-segment driver with double-buffered
//            loads, leading-zero suppression, global blank and per-digit DP.
// Revision : 1.0 - initial release
// ============================================================================
module seven_seg_scan_driver #(
   parameter int NUM_DIGITS  = 4,
   parameter int REFRESH_DIV = 50000,
   parameter int CNT_W       = 16
) (
   input  logic                    Clk,
   input  logic                    Rst,
   input  logic                    LoadEn,
   input  logic [4*NUM_DIGITS-1:0] DataIn,
   input  logic [NUM_DIGITS-1:0]   DpIn,
   input  logic                    LzSuppress,
   input  logic                    BlankEn,
   output logic [6:0]              SegOut,
   output logic                    DpOut,
   output logic [NUM_DIGITS-1:0]   DigitSel,
   output logic                    FrameStart
);

   localparam int               IDX_W       = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [CNT_W-1:0] c_cnt_last  = CNT_W'(REFRESH_DIV - 1);
   localparam logic [IDX_W-1:0] c_idx_last  = IDX_W'(NUM_DIGITS - 1);
   localparam logic [6:0]       c_seg_off   = 7'h7F;

   // Segment order {g,f,e,d,c,b,a}, active-low
   function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
      logic [6:0] seg;
      case (nib)
         4'h0:    seg = 7'h40;
         4'h1:    seg = 7'h79;
         4'h2:    seg = 7'h24;
         4'h3:    seg = 7'h30;
         4'h4:    seg = 7'h19;
         4'h5:    seg = 7'h12;
         4'h6:    seg = 7'h02;
         4'h7:    seg = 7'h78;
         4'h8:    seg = 7'h00;
         4'h9:    seg = 7'h18;
         4'hA:    seg = 7'h08;
         4'hB:    seg = 7'h03;
         4'hC:    seg = 7'h46;
         4'hD:    seg = 7'h21;
         4'hE:    seg = 7'h06;
         default: seg = 7'h0E;
      endcase
      return seg;
   endfunction

   logic [CNT_W-1:0]        cnt_q,        cnt_d;
   logic [IDX_W-1:0]        idx_q,        idx_d;
   logic [4*NUM_DIGITS-1:0] pend_data_q,  pend_data_d;
   logic [NUM_DIGITS-1:0]   pend_dp_q,    pend_dp_d;
   logic                    pend_valid_q, pend_valid_d;
   logic [4*NUM_DIGITS-1:0] disp_data_q,  disp_data_d;
   logic [NUM_DIGITS-1:0]   disp_dp_q,    disp_dp_d;
   logic [6:0]              seg_q,        seg_d;
   logic                    dp_q,         dp_d;
   logic [NUM_DIGITS-1:0]   digit_sel_q,  digit_sel_d;
   logic                    frame_start_q, frame_start_d;

   logic                    tick;
   logic                    frame_bnd;
   logic                    zero_run;
   logic [NUM_DIGITS-1:0]   lz_blank;
   logic [3:0]              cur_nib;
   logic                    cur_dp;
   logic                    cur_lz;

   always_comb begin
      tick      = (cnt_q == c_cnt_last);
      frame_bnd = tick && (idx_q == c_idx_last);

      cnt_d = tick ? '0 : cnt_q + 1'b1;
      idx_d = idx_q;
      if (tick) begin
         idx_d = (idx_q == c_idx_last) ? '0 : idx_q + 1'b1;
      end

      // A load landing on the frame boundary bypasses the pending buffer
      pend_data_d  = pend_data_q;
      pend_dp_d    = pend_dp_q;
      pend_valid_d = pend_valid_q;
      disp_data_d  = disp_data_q;
      disp_dp_d    = disp_dp_q;
      if (LoadEn) begin
         pend_data_d  = DataIn;
         pend_dp_d    = DpIn;
         pend_valid_d = !frame_bnd;
      end else if (frame_bnd) begin
         pend_valid_d = 1'b0;
      end
      if (frame_bnd) begin
         if (LoadEn) begin
            disp_data_d = DataIn;
            disp_dp_d   = DpIn;
         end else if (pend_valid_q) begin
            disp_data_d = pend_data_q;
            disp_dp_d   = pend_dp_q;
         end
      end

      // Digit k is a leading zero when it and every more significant nibble is 0
      zero_run = 1'b1;
      lz_blank = '0;
      for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
         zero_run    = zero_run && (disp_data_q[4*k +: 4] == 4'h0);
         lz_blank[k] = zero_run && (k != 0);
      end

      cur_nib     = 4'h0;
      cur_dp      = 1'b0;
      cur_lz      = 1'b0;
      digit_sel_d = '1;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         if (idx_q == IDX_W'(k)) begin
            cur_nib        = disp_data_q[4*k +: 4];
            cur_dp         = disp_dp_q[k];
            cur_lz         = lz_blank[k];
            digit_sel_d[k] = 1'b0;
         end
      end

      seg_d = hex_to_seg(cur_nib);
      if (BlankEn || (LzSuppress && cur_lz)) begin
         seg_d = c_seg_off;
      end
      dp_d = BlankEn ? 1'b1 : !cur_dp;

      // Digit 0 newly enabled: previous cycle had it off (wrap or reset exit)
      frame_start_d = (idx_q == '0) && digit_sel_q[0];
   end

   always_ff @(posedge Clk) begin
      if (!Rst) begin
         cnt_q         <= '0;
         idx_q         <= '0;
         pend_data_q   <= '0;
         pend_dp_q     <= '0;
         pend_valid_q  <= 1'b0;
         disp_data_q   <= '0;
         disp_dp_q     <= '0;
         seg_q         <= c_seg_off;
         dp_q          <= 1'b1;
         digit_sel_q   <= '1;
         frame_start_q <= 1'b0;
      end else begin
         cnt_q         <= cnt_d;
         idx_q         <= idx_d;
         pend_data_q   <= pend_data_d;
         pend_dp_q     <= pend_dp_d;
         pend_valid_q  <= pend_valid_d;
         disp_data_q   <= disp_data_d;
         disp_dp_q     <= disp_dp_d;
         seg_q         <= seg_d;
         dp_q          <= dp_d;
         digit_sel_q   <= digit_sel_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign SegOut     = seg_q;
   assign DpOut      = dp_q;
   assign DigitSel   = digit_sel_q;
   assign FrameStart = frame_start_q;

endmodule
`default_nettype wire

// File: tb/tb_seven_seg_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_seven_seg_scan_driver
// Brief    : Scoreboard bench for seven_seg_scan_driver (4 digits, 4-cycle slots).
// Revision : 1.0 - initial release
// ============================================================================
module tb_seven_seg_scan_driver;

   logic        clk;
   logic        rst_n;
   logic        load_en;
   logic [15:0] data_in;
   logic [3:0]  dp_in;
   logic        lz_suppress;
   logic        blank_en;
   logic [6:0]  seg_out;
   logic        dp_out;
   logic [3:0]  digit_sel;
   logic        frame_start;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic       anyc;   // 1: check at next sample; 0: check at next digit-slot start
      logic [3:0] sel;
      logic [6:0] seg;
      logic       dp;
      logic       fs;
      string      name;
   } exp_t;

   exp_t sb[$];

   seven_seg_scan_driver #(
      .NUM_DIGITS (4),
      .REFRESH_DIV(4),
      .CNT_W      (16)
   ) dut (
      .Clk       (clk),
      .Rst       (rst_n),
      .LoadEn    (load_en),
      .DataIn    (data_in),
      .DpIn      (dp_in),
      .LzSuppress(lz_suppress),
      .BlankEn   (blank_en),
      .SegOut    (seg_out),
      .DpOut     (dp_out),
      .DigitSel  (digit_sel),
      .FrameStart(frame_start)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push(input logic anyc, input logic [3:0] sel, input logic [6:0] seg,
                       input logic dp, input logic fs, input string nm);
      exp_t e;
      e.anyc = anyc; e.sel = sel; e.seg = seg; e.dp = dp; e.fs = fs; e.name = nm;
      sb.push_back(e);
   endtask

   // One full frame, digit 0 first; dpl is the expected active-low DP per digit
   task automatic push_frame(input logic [6:0] s0, input logic [6:0] s1, input logic [6:0] s2,
                             input logic [6:0] s3, input logic [3:0] dpl, input string nm);
      push(1'b0, 4'hE, s0, dpl[0], 1'b1, {nm, "_d0"});
      push(1'b0, 4'hD, s1, dpl[1], 1'b0, {nm, "_d1"});
      push(1'b0, 4'hB, s2, dpl[2], 1'b0, {nm, "_d2"});
      push(1'b0, 4'h7, s3, dpl[3], 1'b0, {nm, "_d3"});
   endtask

   // Returns one time unit after the edge that raises FrameStart
   task automatic wait_frame(input string nm);
      int n;
      n = 0;
      do begin
         step(1);
         n++;
      end while (frame_start !== 1'b1 && n < 40);
      if (frame_start !== 1'b1) begin
         checks++;
         failures++;
         $display("FAIL wait_frame_%s: FrameStart=%b after %0d cycles, required 1", nm, frame_start, n);
      end
   endtask

   initial begin : monitor
      logic [3:0] prev_sel;
      logic       slot_start;
      logic       fs_exp;
      exp_t       e;
      prev_sel = 4'bxxxx;
      forever begin
         @(negedge clk);
         slot_start = (digit_sel !== prev_sel);
         prev_sel   = digit_sel;
         if (!$isunknown(digit_sel)) begin
            fs_exp = slot_start && (digit_sel == 4'hE);
            checks++;
            if (frame_start !== fs_exp) begin
               failures++;
               $display("FAIL frame_start_align: FrameStart=%b DigitSel=%h, required FrameStart=%b",
                        frame_start, digit_sel, fs_exp);
            end
         end
         if (sb.size() != 0 && (sb[0].anyc || slot_start)) begin
            e = sb.pop_front();
            checks++;
            if ({digit_sel, seg_out, dp_out, frame_start} !== {e.sel, e.seg, e.dp, e.fs}) begin
               failures++;
               $display("FAIL %s: sel=%h seg=%h dp=%b fs=%b, required sel=%h seg=%h dp=%b fs=%b",
                        e.name, digit_sel, seg_out, dp_out, frame_start, e.sel, e.seg, e.dp, e.fs);
            end
         end
      end
   end

   initial begin : stimulus
      int n;
      rst_n       = 1'b0;
      load_en     = 1'b0;
      data_in     = 16'h0000;
      dp_in       = 4'b0000;
      lz_suppress = 1'b0;
      blank_en    = 1'b0;

      // Reset held three cycles
      for (int i = 0; i < 3; i++) begin
         step(1);
         push(1'b1, 4'hF, 7'h7F, 1'b1, 1'b0, "reset_hold");
      end
      rst_n = 1'b1;

      // Two frames of zeros after release
      wait_frame("rel");
      push_frame(7'h40, 7'h40, 7'h40, 7'h40, 4'hF, "rel_f0");
      push_frame(7'h40, 7'h40, 7'h40, 7'h40, 4'hF, "rel_f1");
      wait_frame("f1");

      // Mid-frame load during digit 1; the rest of this frame stays old
      step(4);
      load_en = 1'b1; data_in = 16'h12AF; dp_in = 4'b0000;
      step(1);
      load_en = 1'b0;
      wait_frame("f2");
      push_frame(7'h0E, 7'h08, 7'h24, 7'h79, 4'hF, "load_12af");

      // Load on the frame boundary cycle (index 3, last prescaler count)
      step(14);
      load_en = 1'b1; data_in = 16'h0009;
      step(1);
      load_en = 1'b0;
      wait_frame("f3");
      push_frame(7'h18, 7'h40, 7'h40, 7'h40, 4'hF, "bnd_0009");

      // Back-to-back loads: last one wins
      step(2);
      load_en = 1'b1; data_in = 16'h1111;
      step(1);
      data_in = 16'h2222;
      step(1);
      load_en = 1'b0;
      wait_frame("f4");
      push_frame(7'h24, 7'h24, 7'h24, 7'h24, 4'hF, "b2b_2222");

      // Leading-zero suppression with DP on a blanked digit
      lz_suppress = 1'b1;
      step(2);
      load_en = 1'b1; data_in = 16'h0050; dp_in = 4'b1000;
      step(1);
      load_en = 1'b0;
      wait_frame("f5");
      push_frame(7'h40, 7'h12, 7'h7F, 7'h7F, 4'b0111, "lz_0050");

      step(2);
      load_en = 1'b1; data_in = 16'h0000; dp_in = 4'b0000;
      step(1);
      load_en = 1'b0;
      wait_frame("f6");
      push_frame(7'h40, 7'h7F, 7'h7F, 7'h7F, 4'hF, "lz_0000");

      step(2);
      load_en = 1'b1; data_in = 16'h8888; dp_in = 4'b1111;
      step(1);
      load_en = 1'b0;
      wait_frame("f7");

      // Blank toggled mid-digit, then held across slot boundaries
      push(1'b0, 4'hE, 7'h00, 1'b0, 1'b1, "blank_pre");
      step(1);
      blank_en = 1'b1;
      step(1);
      push(1'b1, 4'hE, 7'h7F, 1'b1, 1'b0, "blank_on");
      blank_en = 1'b0;
      step(1);
      push(1'b1, 4'hE, 7'h00, 1'b0, 1'b0, "blank_off");
      blank_en = 1'b1;
      push(1'b0, 4'hD, 7'h7F, 1'b1, 1'b0, "blank_scan_d1");
      push(1'b0, 4'hB, 7'h7F, 1'b1, 1'b0, "blank_scan_d2");
      step(6);
      blank_en = 1'b0;
      push(1'b0, 4'h7, 7'h00, 1'b0, 1'b0, "blank_resume_d3");
      wait_frame("f8");

      // Reset mid-frame discards a pending load
      lz_suppress = 1'b0;
      step(2);
      load_en = 1'b1; data_in = 16'hBEEF; dp_in = 4'b0101;
      step(1);
      load_en = 1'b0;
      step(2);
      rst_n = 1'b0;
      step(1);
      push(1'b1, 4'hF, 7'h7F, 1'b1, 1'b0, "mid_reset");
      rst_n = 1'b1;
      wait_frame("f9");
      push_frame(7'h40, 7'h40, 7'h40, 7'h40, 4'hF, "post_rst_f0");
      push_frame(7'h40, 7'h40, 7'h40, 7'h40, 4'hF, "post_rst_f1");

      n = 0;
      while (sb.size() != 0 && n < 100) begin
         step(1);
         n++;
      end
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
